// File: rtl/if_id_queue.sv
// Fetch-to-decode bundle queue: a DEPTH-entry FIFO of fetch bundles with a
// synchronous mis-prediction flush and zeroed (NOP) outputs whenever empty.
module if_id_queue #(
  parameter int DEPTH  = 4,
  parameter int SLOTS  = 4,
  parameter int INST_W = 16,
  parameter int PC_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mis_pred,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SLOTS*PC_W-1:0]     pc_in,
  input  logic [SLOTS*INST_W-1:0]   inst_in,
  input  logic [SLOTS*PC_W-1:0]     recv_pc_in,
  input  logic [SLOTS-1:0]          pred_result_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SLOTS*PC_W-1:0]     pc_out,
  output logic [SLOTS*INST_W-1:0]   inst_out,
  output logic [SLOTS*PC_W-1:0]     recv_pc_out,
  output logic [SLOTS-1:0]          pred_result_out,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [SLOTS*PC_W-1:0]   pc;
    logic [SLOTS*INST_W-1:0] inst;
    logic [SLOTS*PC_W-1:0]   recv_pc;
    logic [SLOTS-1:0]        pred;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             push;
  logic             pop;

  // NOTE: handshake flags come from the registered count only, so in_ready
  // never depends combinationally on out_ready; a full queue refuses input
  // even when decode drains an entry in the same cycle.
  assign in_ready  = (count_q < FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready & ~mis_pred;
  assign pop       = out_valid & out_ready & ~mis_pred;
  assign count     = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (mis_pred) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array is deliberately left unreset; stale contents are
  // never visible because the read side is gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{pc: pc_in, inst: inst_in, recv_pc: recv_pc_in,
                       pred: pred_result_in};
    end
  end

  // Empty queue presents an all-zero NOP bundle to decode.
  assign head            = out_valid ? mem[rd_ptr] : '0;
  assign pc_out          = head.pc;
  assign inst_out        = head.inst;
  assign recv_pc_out     = head.recv_pc;
  assign pred_result_out = head.pred;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue with default parameters
// (4 entries, 4 slots of 16-bit instructions and PCs).
module tb_if_id_queue;

  logic        clk;
  logic        rst_n;
  logic        mis_pred;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] pc_in;
  logic [63:0] inst_in;
  logic [63:0] recv_pc_in;
  logic [3:0]  pred_result_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] pc_out;
  logic [63:0] inst_out;
  logic [63:0] recv_pc_out;
  logic [3:0]  pred_result_out;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  if_id_queue dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mis_pred        (mis_pred),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .pc_in           (pc_in),
    .inst_in         (inst_in),
    .recv_pc_in      (recv_pc_in),
    .pred_result_in  (pred_result_in),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .pc_out          (pc_out),
    .inst_out        (inst_out),
    .recv_pc_out     (recv_pc_out),
    .pred_result_out (pred_result_out),
    .count           (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    mis_pred       = 1'b0;
    in_valid       = 1'b0;
    out_ready      = 1'b0;
    pc_in          = '0;
    inst_in        = '0;
    recv_pc_in     = '0;
    pred_result_in = '0;

    // Reset state, sampled while reset is held
    #3;
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_inst_out", inst_out, 64'd0);
    #9 rst_n = 1'b1;

    // Single pass: first edge after release accepts the push
    in_valid       = 1'b1;
    inst_in        = 64'h1111_2222_3333_4444;
    pc_in          = 64'h0010_0011_0012_0013;
    recv_pc_in     = 64'hA0A1_A2A3_A4A5_A6A7;
    pred_result_in = 4'b0101;
    out_ready      = 1'b1;
    tick();
    in_valid = 1'b0;
    check("single_out_valid", 64'(out_valid), 64'd1);
    check("single_inst", inst_out, 64'h1111_2222_3333_4444);
    check("single_pc", pc_out, 64'h0010_0011_0012_0013);
    check("single_recv_pc", recv_pc_out, 64'hA0A1_A2A3_A4A5_A6A7);
    check("single_pred", 64'(pred_result_out), 64'h5);
    check("single_count", 64'(count), 64'd1);
    tick();
    check("single_drained_valid", 64'(out_valid), 64'd0);
    check("single_drained_inst", inst_out, 64'd0);
    check("single_drained_pc", pc_out, 64'd0);
    check("single_drained_pred", 64'(pred_result_out), 64'd0);
    check("single_drained_count", 64'(count), 64'd0);

    // Fill and stall: five pushes, the fifth is refused
    out_ready      = 1'b0;
    in_valid       = 1'b1;
    pc_in          = '0;
    recv_pc_in     = '0;
    pred_result_in = '0;
    for (int i = 1; i <= 5; i++) begin
      inst_in = 64'(i);
      tick();
      check($sformatf("fill_count_%0d", i), 64'(count), 64'((i > 4) ? 4 : i));
      check($sformatf("fill_head_%0d", i), inst_out, 64'd1);
    end
    check("fill_in_ready", 64'(in_ready), 64'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("drain_inst_%0d", i), inst_out, 64'(i));
      tick();
    end
    check("drain_count", 64'(count), 64'd0);
    check("drain_out_valid", 64'(out_valid), 64'd0);

    // Full with simultaneous pop
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inst_in = 64'h10 + 64'(i);
      tick();
    end
    check("full_count", 64'(count), 64'd4);
    inst_in   = 64'h14;
    out_ready = 1'b1;
    tick();
    check("full_pop_count", 64'(count), 64'd3);
    check("full_pop_head", inst_out, 64'h11);
    check("full_pop_in_ready", 64'(in_ready), 64'd1);
    inst_in = 64'h15;
    tick();
    check("full_pushpop_count", 64'(count), 64'd3);
    check("full_pushpop_head", inst_out, 64'h12);
    in_valid = 1'b0;
    check("full_seq_0", inst_out, 64'h12);
    tick();
    check("full_seq_1", inst_out, 64'h13);
    tick();
    check("full_seq_2", inst_out, 64'h15);
    tick();
    check("full_seq_empty", 64'(count), 64'd0);

    // Wrap-around: 20 push/pop pairs with two entries resident
    out_ready = 1'b0;
    in_valid  = 1'b1;
    inst_in   = 64'd100;
    tick();
    inst_in = 64'd101;
    tick();
    check("wrap_pre_count", 64'(count), 64'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      inst_in = 64'd102 + 64'(i);
      check($sformatf("wrap_head_%0d", i), inst_out, 64'd100 + 64'(i));
      tick();
      check($sformatf("wrap_count_%0d", i), 64'(count), 64'd2);
    end
    in_valid = 1'b0;
    check("wrap_tail_0", inst_out, 64'd120);
    tick();
    check("wrap_tail_1", inst_out, 64'd121);
    tick();
    check("wrap_empty", 64'(count), 64'd0);

    // Flush with simultaneous push and pop
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      inst_in = 64'h200 + 64'(i);
      tick();
    end
    check("flush_pre_count", 64'(count), 64'd3);
    mis_pred  = 1'b1;
    inst_in   = 64'h203;
    out_ready = 1'b1;
    tick();
    mis_pred = 1'b0;
    check("flush_count", 64'(count), 64'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_inst", inst_out, 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b0;
    inst_in   = 64'h300;
    tick();
    check("flush_next_valid", 64'(out_valid), 64'd1);
    check("flush_next_inst", inst_out, 64'h300);
    check("flush_next_count", 64'(count), 64'd1);
    inst_in = 64'h301;
    tick();
    in_valid = 1'b0;
    check("areset_pre_count", 64'(count), 64'd2);

    // Asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    check("areset_count", 64'(count), 64'd0);
    check("areset_out_valid", 64'(out_valid), 64'd0);
    check("areset_inst", inst_out, 64'd0);
    check("areset_in_ready", 64'(in_ready), 64'd1);
    #3 rst_n = 1'b1;
    tick();
    check("post_reset_count", 64'(count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
